// File: rtl/miner_dispatch.sv
// miner_dispatch: fans a work block out to NUM_CORES miner cores, restarts
// them together on disjoint nonce ranges, and funnels their golden nonces
// back to the serial transmitter one at a time through a round-robin arbiter.

module miner_dispatch #(
    parameter int NUM_CORES    = 4,
    parameter int CORE_BITS    = 2,
    parameter int RESET_CYCLES = 4,
    parameter int HOLDOFF      = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      new_block,
    input  logic [351:0]              block,
    output logic [351:0]              core_block,
    output logic [NUM_CORES-1:0]      core_reset,
    output logic [32*NUM_CORES-1:0]   core_nonce_start,
    input  logic [NUM_CORES-1:0]      core_found,
    input  logic [32*NUM_CORES-1:0]   core_nonce,
    input  logic                      tx_busy,
    output logic                      result_ready,
    output logic [31:0]               result,
    output logic                      running,
    output logic [7:0]                dropped
);

    // Counter widths sized to hold their load values; never zero width.
    localparam int CNT_W  = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       load_cnt;
    logic [HOLD_W-1:0]      holdoff_cnt;
    logic [CORE_BITS-1:0]   rr_ptr;
    logic [NUM_CORES-1:0]   pending;
    logic [31:0]            pend_nonce [NUM_CORES];

    logic                   capture_en;
    logic                   grant_valid;
    logic [CORE_BITS-1:0]   grant_idx;
    logic [NUM_CORES-1:0]   grant_oh;
    logic [CORE_BITS-1:0]   scan_idx;
    logic                   scan_hit;
    logic [NUM_CORES-1:0]   drop_vec;
    logic                   any_drop;

    // Each core starts at the bottom of its own slice of the 32-bit nonce space.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_nonce_start
            assign core_nonce_start[32*gi +: 32] = 32'(gi) << (32 - CORE_BITS);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the core restart and running outputs.
    always_comb begin
        state_next = state;
        core_reset = '1;
        running    = 1'b0;
        case (state)
            IDLE: begin
                if (new_block) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (new_block) begin
                    state_next = LOAD;
                end else if (load_cnt == '0) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                core_reset = '0;
                running    = 1'b1;
                if (new_block) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holds the cores in restart for RESET_CYCLES cycles after each new block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_cnt <= '0;
        end else if (new_block) begin
            load_cnt <= CNT_W'(RESET_CYCLES - 1);
        end else if (state == LOAD && load_cnt != '0) begin
            load_cnt <= load_cnt - CNT_W'(1);
        end
    end

    // Latches the work block shared by all cores.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_block <= '0;
        end else if (new_block) begin
            core_block <= block;
        end
    end

    // Round-robin search for the first pending core at or after rr_ptr;
    // a new block suppresses the grant so stale work is never reported.
    always_comb begin
        capture_en  = (state == RUN) && !new_block;
        grant_valid = (state == RUN) && (|pending) && !tx_busy &&
                      (holdoff_cnt == '0) && !new_block;
        grant_idx   = '0;
        scan_idx    = '0;
        scan_hit    = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = rr_ptr + CORE_BITS'(k);
            if (!scan_hit && pending[scan_idx]) begin
                grant_idx = scan_idx;
                scan_hit  = 1'b1;
            end
        end
        grant_oh = grant_valid ? (NUM_CORES'(1) << grant_idx) : '0;
        drop_vec = capture_en ? (core_found & pending & ~grant_oh) : '0;
        any_drop = |drop_vec;
    end

    // One-deep result buffer per core; a core granted this cycle may refill.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_nonce[i] <= '0;
            end
        end else if (new_block) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (capture_en && core_found[i] && (!pending[i] || grant_oh[i])) begin
                    pend_nonce[i] <= core_nonce[32*i +: 32];
                    pending[i]    <= 1'b1;
                end else if (grant_oh[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Registers the granted nonce, advances the pointer and spaces out strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_ready <= 1'b0;
            result       <= '0;
            rr_ptr       <= '0;
            holdoff_cnt  <= '0;
        end else begin
            result_ready <= grant_valid;
            if (grant_valid) begin
                result      <= pend_nonce[grant_idx];
                rr_ptr      <= grant_idx + CORE_BITS'(1);
                holdoff_cnt <= HOLD_W'(HOLDOFF);
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HOLD_W'(1);
            end
        end
    end

    // Saturating count of cycles in which at least one result was lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropped <= '0;
        end else if (any_drop && dropped != 8'hFF) begin
            dropped <= dropped + 8'd1;
        end
    end

endmodule

// File: tb/tb_miner_dispatch.sv
// tb_miner_dispatch: directed checks of load sequencing, capture, round-robin
// output arbitration, drop counting and reset behaviour of miner_dispatch.

module tb_miner_dispatch;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           new_block;
    logic [351:0]   block;
    logic [351:0]   core_block;
    logic [3:0]     core_reset;
    logic [127:0]   core_nonce_start;
    logic [3:0]     core_found;
    logic [127:0]   core_nonce;
    logic           tx_busy;
    logic           result_ready;
    logic [31:0]    result;
    logic           running;
    logic [7:0]     dropped;

    int             checks = 0;
    int             errors = 0;

    logic [351:0]   blk_a;
    logic [351:0]   blk_b;
    logic [31:0]    seen_val [16];
    int             seen_cyc [16];
    int             seen_n;

    miner_dispatch #(
        .NUM_CORES(4),
        .CORE_BITS(2),
        .RESET_CYCLES(4),
        .HOLDOFF(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .new_block(new_block),
        .block(block),
        .core_block(core_block),
        .core_reset(core_reset),
        .core_nonce_start(core_nonce_start),
        .core_found(core_found),
        .core_nonce(core_nonce),
        .tx_busy(tx_busy),
        .result_ready(result_ready),
        .result(result),
        .running(running),
        .dropped(dropped)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Runs n cycles observing at the falling edge, dropping one-cycle pulses
    // after the first cycle and recording every result strobe.
    task automatic run_and_record(input int n);
        seen_n = 0;
        for (int j = 0; j < 16; j++) begin
            seen_val[j] = 32'h0;
            seen_cyc[j] = -1;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                core_found = '0;
                new_block  = 1'b0;
            end
            if (result_ready === 1'b1 && seen_n < 16) begin
                seen_val[seen_n] = result;
                seen_cyc[seen_n] = k;
                seen_n++;
            end
        end
    endtask

    // Resets the DUT, loads blk_a and returns in the first RUN cycle.
    task automatic do_reset_and_load();
        reset_n    = 1'b0;
        new_block  = 1'b0;
        core_found = '0;
        tx_busy    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        block     = blk_a;
        new_block = 1'b1;
        @(negedge clk);
        new_block = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        new_block  = 1'b0;
        block      = '0;
        core_found = '0;
        core_nonce = '0;
        tx_busy    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (core_block !== 352'h0) begin
            errors++;
            $display("[TB] FAIL reset_core_block: got %h want 0", core_block);
        end
        checks++;
        if (core_reset !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_core_reset: got %h want f", core_reset);
        end
        checks++;
        if (result_ready !== 1'b0 || result !== 32'h0 || running !== 1'b0 || dropped !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b res=%h run=%b drop=%0d want 0/0/0/0",
                     result_ready, result, running, dropped);
        end
        checks++;
        if (core_nonce_start !== {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}) begin
            errors++;
            $display("[TB] FAIL nonce_start: got %h want c0000000800000004000000000000000",
                     core_nonce_start);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (core_reset !== 4'hF || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got core_reset=%h run=%b want f/0", core_reset, running);
        end
    endtask

    task automatic test_load();
        block     = blk_a;
        new_block = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                new_block = 1'b0;
                block     = '0;
                checks++;
                if (core_block !== blk_a) begin
                    errors++;
                    $display("[TB] FAIL load_core_block: got %h want %h", core_block, blk_a);
                end
            end
            checks++;
            if (core_reset !== 4'hF || running !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_hold_c%0d: got core_reset=%h run=%b want f/0",
                         k, core_reset, running);
            end
        end
        @(negedge clk);
        checks++;
        if (core_reset !== 4'h0 || running !== 1'b1 || core_block !== blk_a) begin
            errors++;
            $display("[TB] FAIL load_run: got core_reset=%h run=%b blk_ok=%b want 0/1/1",
                     core_reset, running, core_block === blk_a);
        end
    endtask

    task automatic test_single();
        do_reset_and_load();
        core_nonce[32*2 +: 32] = 32'h1234_5678;
        core_found = 4'b0100;
        run_and_record(4);
        checks++;
        if (seen_n !== 1 || seen_cyc[0] !== 2) begin
            errors++;
            $display("[TB] FAIL single_timing: got %0d strobes first at %0d want 1 at 2",
                     seen_n, seen_cyc[0]);
        end
        checks++;
        if (seen_val[0] !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL single_value: got %h want 12345678", seen_val[0]);
        end
        checks++;
        if (result_ready !== 1'b0 || result !== 32'h1234_5678 || dropped !== 8'h0) begin
            errors++;
            $display("[TB] FAIL single_hold: got rdy=%b res=%h drop=%0d want 0/12345678/0",
                     result_ready, result, dropped);
        end
    endtask

    task automatic test_round_robin();
        do_reset_and_load();
        core_nonce[32*0 +: 32] = 32'h10;
        core_nonce[32*1 +: 32] = 32'h11;
        core_nonce[32*3 +: 32] = 32'h13;
        core_found = 4'b1011;
        run_and_record(12);
        checks++;
        if (seen_n !== 3) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d strobes want 3", seen_n);
        end
        checks++;
        if (seen_val[0] !== 32'h10 || seen_cyc[0] !== 2) begin
            errors++;
            $display("[TB] FAIL rr_first: got %h at %0d want 10 at 2", seen_val[0], seen_cyc[0]);
        end
        checks++;
        if (seen_val[1] !== 32'h11 || seen_cyc[1] !== 5) begin
            errors++;
            $display("[TB] FAIL rr_second: got %h at %0d want 11 at 5", seen_val[1], seen_cyc[1]);
        end
        checks++;
        if (seen_val[2] !== 32'h13 || seen_cyc[2] !== 8) begin
            errors++;
            $display("[TB] FAIL rr_third: got %h at %0d want 13 at 8", seen_val[2], seen_cyc[2]);
        end
        core_nonce[32*0 +: 32] = 32'h20;
        core_nonce[32*3 +: 32] = 32'h23;
        core_found = 4'b1001;
        run_and_record(8);
        checks++;
        if (seen_n !== 2 || seen_val[0] !== 32'h20 || seen_val[1] !== 32'h23) begin
            errors++;
            $display("[TB] FAIL rr_wrap_order: got n=%0d %h,%h want 2 20,23",
                     seen_n, seen_val[0], seen_val[1]);
        end
        checks++;
        if (seen_cyc[0] !== 2 || seen_cyc[1] !== 5) begin
            errors++;
            $display("[TB] FAIL rr_wrap_timing: got %0d,%0d want 2,5", seen_cyc[0], seen_cyc[1]);
        end
    endtask

    task automatic test_busy_drop();
        tx_busy = 1'b1;
        core_nonce[32*1 +: 32] = 32'hAAAA_0001;
        core_found = 4'b0010;
        run_and_record(3);
        checks++;
        if (seen_n !== 0) begin
            errors++;
            $display("[TB] FAIL busy_block: got %0d strobes want 0", seen_n);
        end
        core_nonce[32*1 +: 32] = 32'hBBBB_0002;
        core_found = 4'b0010;
        run_and_record(2);
        checks++;
        if (dropped !== 8'd1 || seen_n !== 0) begin
            errors++;
            $display("[TB] FAIL busy_drop: got dropped=%0d strobes=%0d want 1/0", dropped, seen_n);
        end
        tx_busy = 1'b0;
        run_and_record(6);
        checks++;
        if (seen_n !== 1 || seen_cyc[0] !== 1) begin
            errors++;
            $display("[TB] FAIL busy_release_count: got %0d strobes first at %0d want 1 at 1",
                     seen_n, seen_cyc[0]);
        end
        checks++;
        if (seen_val[0] !== 32'hAAAA_0001) begin
            errors++;
            $display("[TB] FAIL busy_release_value: got %h want aaaa0001", seen_val[0]);
        end
    endtask

    task automatic test_new_block_flush();
        int strobes;
        tx_busy = 1'b1;
        core_nonce[32*0 +: 32] = 32'h31;
        core_nonce[32*2 +: 32] = 32'h33;
        core_found = 4'b0101;
        @(negedge clk);
        core_found = '0;
        @(negedge clk);
        block      = blk_b;
        new_block  = 1'b1;
        core_nonce[32*3 +: 32] = 32'h3F;
        core_found = 4'b1000;
        tx_busy    = 1'b0;
        strobes    = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                new_block  = 1'b0;
                core_found = '0;
            end
            if (result_ready === 1'b1) begin
                strobes++;
            end
            if (k <= 4) begin
                checks++;
                if (core_reset !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL flush_reload_c%0d: got core_reset=%h want f", k, core_reset);
                end
            end
            if (k == 5) begin
                checks++;
                if (core_reset !== 4'h0 || running !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL flush_run: got core_reset=%h run=%b want 0/1",
                             core_reset, running);
                end
            end
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("[TB] FAIL flush_no_strobe: got %0d strobes want 0", strobes);
        end
        checks++;
        if (core_block !== blk_b || dropped !== 8'd1) begin
            errors++;
            $display("[TB] FAIL flush_block_drop: got blk_ok=%b dropped=%0d want 1/1",
                     core_block === blk_b, dropped);
        end
    endtask

    task automatic test_reset_mid_run();
        int strobes;
        tx_busy = 1'b1;
        core_nonce[32*0 +: 32] = 32'h41;
        core_nonce[32*1 +: 32] = 32'h42;
        core_found = 4'b0011;
        @(negedge clk);
        core_found = '0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (core_block !== 352'h0 || core_reset !== 4'hF || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got blk_zero=%b core_reset=%h run=%b want 1/f/0",
                     core_block === 352'h0, core_reset, running);
        end
        checks++;
        if (result_ready !== 1'b0 || result !== 32'h0 || dropped !== 8'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got rdy=%b res=%h drop=%0d want 0/0/0",
                     result_ready, result, dropped);
        end
        reset_n = 1'b1;
        tx_busy = 1'b0;
        strobes = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (result_ready === 1'b1) begin
                strobes++;
            end
        end
        checks++;
        if (strobes !== 0 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got strobes=%0d run=%b want 0/0", strobes, running);
        end
    endtask

    task automatic test_saturate();
        do_reset_and_load();
        tx_busy = 1'b1;
        core_nonce[32*0 +: 32] = 32'h51;
        core_nonce[32*1 +: 32] = 32'h52;
        core_found = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        core_found = '0;
        checks++;
        if (dropped !== 8'd1) begin
            errors++;
            $display("[TB] FAIL sat_multi_drop: got %0d want 1", dropped);
        end
        core_found = 4'b0001;
        repeat (99) @(negedge clk);
        core_found = '0;
        checks++;
        if (dropped !== 8'd100) begin
            errors++;
            $display("[TB] FAIL sat_100: got %0d want 100", dropped);
        end
        core_found = 4'b0001;
        repeat (154) @(negedge clk);
        core_found = '0;
        checks++;
        if (dropped !== 8'd254) begin
            errors++;
            $display("[TB] FAIL sat_254: got %0d want 254", dropped);
        end
        core_found = 4'b0001;
        repeat (46) @(negedge clk);
        core_found = '0;
        checks++;
        if (dropped !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_255: got %0d want 255", dropped);
        end
        tx_busy = 1'b0;
    endtask

    // Bounds the whole run in case the DUT or bench stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        blk_a = {44{8'hA5}};
        blk_b = {11{32'h5A5A_1234}};
        test_reset();
        test_load();
        test_single();
        test_round_robin();
        test_busy_drop();
        test_new_block_flush();
        test_reset_mid_run();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
